// File: rtl/alu_pkg.sv
// Shared opcode encodings and result-entry layout for the ALU result stage.
// An entry is packed {y, z, op}: WIDTH result bits, one zero flag, three opcode bits.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int OP_W          = 3;
  localparam int ENTRY_META_W  = 1 + OP_W;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b100
  } alu_op_e;

  function automatic int entry_width(input int width);
    return width + ENTRY_META_W;
  endfunction

  // Undefined opcodes never match OP_DIV, so they can never raise the error.
  function automatic logic is_div_by_zero(input logic [0:OP_W-1] op,
                                          input logic            b_zero);
    return (op == OP_DIV) && b_zero;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Parameterised synchronous FIFO: wrapping pointers plus a separate 0..DEPTH level counter.
// The head is read combinationally from storage; there is no write-to-read bypass.
module result_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level alone
  // decide which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage behind the combinational ALU: buffers {y, z, op} in a FIFO and
// maintains the accumulator, sticky divide-by-zero flag and accepted-operation count.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [0:WIDTH-1]       y_in,
  input  logic                   z_in,
  input  logic [0:2]             op_in,
  input  logic                   b_zero_in,
  input  logic                   acc_en_in,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [0:WIDTH-1]       y_out,
  output logic                   z_out,
  output logic [0:2]             op_out,
  output logic [0:WIDTH-1]       acc_out,
  output logic                   err_out,
  input  logic                   clr_err_in,
  output logic [0:CNT_W-1]       count_out,
  output logic [0:$clog2(DEPTH)] level_out
);

  localparam int ENTRY_W = entry_width(WIDTH);

  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [0:WIDTH-1]   head_y;
  logic               head_z;
  logic [0:2]         head_op;

  // ready_out depends only on the registered level, never on ready_in.
  assign ready_out = !fifo_full;
  assign valid_out = !fifo_empty;
  assign push      = valid_in && ready_out;
  assign pop       = valid_out && ready_in;

  assign fifo_din                    = {y_in, z_in, op_in};
  assign {head_y, head_z, head_op}   = fifo_dout;

  result_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_out)
  );

  // Stale storage is masked so the head reads zero while the FIFO is empty.
  assign y_out  = valid_out ? head_y  : '0;
  assign z_out  = valid_out ? head_z  : 1'b0;
  assign op_out = valid_out ? head_op : '0;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      acc_out   <= '0;
      err_out   <= 1'b0;
      count_out <= '0;
    end else begin
      if (push && acc_en_in) acc_out <= y_in;
      // A new divide-by-zero wins over a simultaneous clear.
      if (push && is_div_by_zero(op_in, b_zero_in)) err_out <= 1'b1;
      else if (clr_err_in)                          err_out <= 1'b0;
      if (push) count_out <= count_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed literal expectations and randomized traffic.
module tb_alu_result_stage;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             valid_in;
  logic             ready_out;
  logic [0:WIDTH-1] y_in;
  logic             z_in;
  logic [0:2]       op_in;
  logic             b_zero_in;
  logic             acc_en_in;
  logic             valid_out;
  logic             ready_in;
  logic [0:WIDTH-1] y_out;
  logic             z_out;
  logic [0:2]       op_out;
  logic [0:WIDTH-1] acc_out;
  logic             err_out;
  logic             clr_err_in;
  logic [0:CNT_W-1] count_out;
  logic [0:2]       level_out;

  alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .y_in       (y_in),
    .z_in       (z_in),
    .op_in      (op_in),
    .b_zero_in  (b_zero_in),
    .acc_en_in  (acc_en_in),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .y_out      (y_out),
    .z_out      (z_out),
    .op_out     (op_out),
    .acc_out    (acc_out),
    .err_out    (err_out),
    .clr_err_in (clr_err_in),
    .count_out  (count_out),
    .level_out  (level_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of {y, z, op} entries plus scalar state.
  typedef struct {
    logic [31:0] y;
    logic        z;
    logic [2:0]  op;
  } entry_t;

  entry_t      q[$];
  logic [31:0] m_acc = '0;
  logic        m_err = 1'b0;
  logic [15:0] m_cnt = '0;
  bit          model_live = 1'b0;

  always @(posedge clk_in) begin
    bit m_push;
    bit m_pop;
    entry_t e;
    if (!rst_n_in) begin
      q.delete();
      m_acc = '0;
      m_err = 1'b0;
      m_cnt = '0;
      model_live = 1'b1;
    end else if (model_live) begin
      m_push = valid_in && (q.size() < DEPTH);
      m_pop  = ready_in && (q.size() > 0);
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        e.y = y_in; e.z = z_in; e.op = op_in;
        q.push_back(e);
        if (acc_en_in) m_acc = y_in;
        m_cnt = m_cnt + 16'd1;
      end
      if (m_push && op_in == 3'b100 && b_zero_in) m_err = 1'b1;
      else if (clr_err_in)                        m_err = 1'b0;
    end
  end

  always @(negedge clk_in) begin
    if (model_live) begin
      check("ready_out", ready_out, q.size() < DEPTH);
      check("valid_out", valid_out, q.size() > 0);
      check("level_out", level_out, q.size());
      check("y_out",     y_out,  q.size() > 0 ? q[0].y  : 32'd0);
      check("z_out",     z_out,  q.size() > 0 ? q[0].z  : 1'b0);
      check("op_out",    op_out, q.size() > 0 ? q[0].op : 3'd0);
      check("acc_out",   acc_out, m_acc);
      check("err_out",   err_out, m_err);
      check("count_out", count_out, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] y, input logic z, input logic [2:0] op,
                       input bit bz, input bit acc);
    valid_in = v; y_in = y; z_in = z; op_in = op; b_zero_in = bz; acc_en_in = acc;
  endtask

  initial begin
    rst_n_in = 1'b0; ready_in = 1'b1; clr_err_in = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    rst_n_in = 1'b1;
    check("rst valid_out", valid_out, 0);
    check("rst ready_out", ready_out, 1);
    check("rst level_out", level_out, 0);
    check("rst acc_out",   acc_out, 0);
    check("rst err_out",   err_out, 0);
    check("rst count_out", count_out, 0);
    check("rst y_out",     y_out, 0);

    // First push: visible one cycle later, popped the cycle after.
    drive(1, 2, 0, 3'b000, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("t1 valid_out", valid_out, 1);
    check("t1 y_out",     y_out, 2);
    check("t1 z_out",     z_out, 0);
    check("t1 acc_out",   acc_out, 2);
    check("t1 count_out", count_out, 1);
    step();
    check("t1 valid_out drained", valid_out, 0);

    // Divide-by-zero sets sticky error; set beats clear; clear alone clears.
    drive(1, 0, 1, 3'b100, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("div err set", err_out, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("div err sticky", err_out, 1);
    end
    drive(1, 0, 1, 3'b100, 1, 0);
    clr_err_in = 1'b1;
    step();
    check("div set wins", err_out, 1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    clr_err_in = 1'b0;
    check("div cleared", err_out, 0);
    step(); step();

    // Fill to full with back-pressure, reject a fifth, then drain in order.
    ready_in = 1'b0;
    drive(1, 50, 0, 3'b001, 0, 0);  step();
    drive(1, 0, 1, 3'b001, 0, 0);   step();
    drive(1, 625, 0, 3'b010, 0, 0); step();
    drive(1, 10, 0, 3'b000, 0, 0);  step();
    check("full ready_out", ready_out, 0);
    check("full level_out", level_out, 4);
    drive(1, 7, 0, 3'b000, 0, 0);   step();
    drive(0, 0, 0, 0, 0, 0);
    check("full reject level", level_out, 4);
    check("full reject count", count_out, 7);
    ready_in = 1'b1;
    check("drain 0", y_out, 50);  step();
    check("drain 1", y_out, 0);   step();
    check("drain 2", y_out, 625); step();
    check("drain 3", y_out, 10);  step();
    check("drain empty", valid_out, 0);

    // Hold level 2 with simultaneous push/pop across pointer wrap.
    ready_in = 1'b0;
    drive(1, 1, 0, 3'b000, 0, 0); step();
    drive(1, 2, 0, 3'b000, 0, 0); step();
    check("wrap head", y_out, 1);
    ready_in = 1'b1;
    drive(1, 100, 0, 3'b000, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("wrap level", level_out, 2);
      check("wrap head", y_out, (k == 1) ? 32'd2 : 32'd100);
    end
    drive(0, 0, 0, 0, 0, 0);
    step(); step(); step();

    // Synchronous reset mid-operation; an inter-edge pulse is ignored.
    ready_in = 1'b0;
    drive(1, 5, 0, 3'b000, 0, 1);   step();
    drive(1, 6, 0, 3'b000, 0, 1);   step();
    drive(1, 625, 0, 3'b000, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0);
    check("pre-rst acc", acc_out, 625);
    check("pre-rst level", level_out, 3);
    rst_n_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    check("mid-rst valid_out", valid_out, 0);
    check("mid-rst level_out", level_out, 0);
    check("mid-rst acc_out",   acc_out, 0);
    check("mid-rst count_out", count_out, 0);
    check("mid-rst ready_out", ready_out, 1);
    drive(1, 9, 0, 3'b000, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    rst_n_in = 1'b0; #2; rst_n_in = 1'b1;
    step();
    check("glitch level", level_out, 1);
    check("glitch y_out", y_out, 9);
    ready_in = 1'b1;
    step();

    // Randomized traffic, including undefined opcodes and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 2) != 0,
            ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
            $urandom_range(0, 1), 3'($urandom_range(0, 7)),
            $urandom_range(0, 1), $urandom_range(0, 1));
      ready_in   = $urandom_range(0, 2) != 0;
      clr_err_in = $urandom_range(0, 7) == 0;
      rst_n_in   = $urandom_range(0, 149) != 0;
      step();
    end
    rst_n_in = 1'b1; clr_err_in = 1'b0;

    // Counter wrap: reset, then 65535 back-to-back accepts reach 0xFFFF.
    drive(0, 0, 0, 0, 0, 0);
    rst_n_in = 1'b0; step(); rst_n_in = 1'b1;
    ready_in = 1'b1;
    drive(1, 3, 0, 3'b000, 0, 0);
    for (int i = 0; i < 65535; i++) step();
    check("count max", count_out, 16'hFFFF);
    step();
    check("count wrap", count_out, 0);
    drive(0, 0, 0, 0, 0, 0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered stage directly downstream of the combinational ALU (a_in/b_in/op_in -> y_out/z_out).
- Captures each valid ALU result together with its zero flag and opcode, and updates the accumulator (ACC) on request.
- Tracks a sticky divide-by-zero error flag and buffers results in a small FIFO with valid/ready handshakes.
- Back-pressures the issue logic (ready_out) and feeds the writeback/consumer side (valid_out/ready_in).

Parameters:
WIDTH, 32, datapath width; MSB-first bit ordering [0:WIDTH-1], same as the ALU
DEPTH, 4, result FIFO entries; power of two, >=2
CNT_W, 16, width of the completed-operation counter

Ports:
clk_in  in  1  clock, rising edge
rst_n_in  in  1  reset, synchronous, active-low
valid_in  in  1  ALU result on y_in/z_in/op_in is valid this cycle
ready_out  out  1  stage can accept a result
y_in  in  [0:WIDTH-1]  ALU y_out
z_in  in  1  ALU z_out
op_in  in  [0:2]  opcode that produced y_in
b_zero_in  in  1  ALU b operand was zero
acc_en_in  in  1  write y_in into ACC on accept
valid_out  out  1  FIFO head valid
ready_in  in  1  consumer takes head
y_out  out  [0:WIDTH-1]  head result
z_out  out  1  head zero flag
op_out  out  [0:2]  head opcode
acc_out  out  [0:WIDTH-1]  accumulator
err_out  out  1  sticky divide-by-zero
clr_err_in  in  1  clear err_out
count_out  out  [0:CNT_W-1]  accepted-operation counter
level_out  out  [0:$clog2(DEPTH)]  FIFO occupancy

Behaviour:
- Reset: when rst_n_in=0 at a clock edge, clear all state. ACC=0, err_out=0, count_out=0, level_out=0, valid_out=0, ready_out=1. y_out, z_out and op_out read 0 while empty.
- Reset mid-operation discards all buffered entries. No pop is reported in that cycle.
- Accept condition: push = valid_in && ready_out. ready_out = (level < DEPTH), registered-level based, with no combinational dependency on ready_in. When full, ready_out=0 even if a pop occurs the same cycle.
- Pop condition: pop = valid_out && ready_in. valid_out = (level > 0).
- Output timing: y_out, z_out and op_out show the FIFO head combinationally from storage. Latency from accept to valid_out is 1 cycle when the FIFO is empty.
- Simultaneous push and pop (not full, not empty): level is unchanged and both pointers advance.
- Push into an empty FIFO with ready_in=1: the entry appears next cycle; there is no same-cycle bypass.
- Pointers: rd/wr pointers are log2(DEPTH) bits and wrap modulo DEPTH. Level is a separate up/down counter from 0 to DEPTH.
- Occupancy states:
  - EMPTY: level=0. push -> PARTIAL (or FULL if DEPTH=1, which is disallowed).
  - PARTIAL: push only -> level+1, FULL if level reaches DEPTH. pop only -> level-1, EMPTY if level reaches 0. Both -> stay.
  - FULL: pop -> PARTIAL. push is impossible (ready_out=0).
- ACC: on push with acc_en_in=1, ACC <= y_in. Otherwise ACC holds.
- z_in is stored verbatim and not recomputed. The stage does not check consistency between y_in and z_in.
- err_out: set on push when op_in=OP_DIV and b_zero_in=1. Cleared by clr_err_in=1. If set and clear occur in the same cycle, set wins.
- count_out increments by 1 per push and wraps from 2^CNT_W-1 to 0.
- Undefined opcodes (011, 101, 110, 111) are buffered unchanged and never set err_out.

Decomposition:
- Package alu_pkg holds:
  - OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010, OP_DIV=3'b100
  - default WIDTH
  - FIFO entry layout {y, z, op}, width WIDTH+4
- One sub-module: result_fifo. It is a parameterised synchronous FIFO with push/pop/full/empty/level.
- alu_result_stage wraps result_fifo and adds the ACC, err and count registers.

Test Plan:
- Reset then push y=2, z=0, op=000, acc_en=1 with ready_in=1:
  - next cycle valid_out=1, y_out=2, z_out=0, acc_out=2, count_out=1
  - the following cycle valid_out=0
- Push op=100, y=0, z=1, b_zero=1:
  - err_out=1 next cycle and stays 1 for 10 cycles
  - clr_err_in and a second div-by-zero push in the same cycle -> err_out remains 1
  - clr_err_in alone -> err_out=0
- ready_in=0, push results 50, 0, 625, 10, then assert valid_in with 7:
  - ready_out=0 after the 4th accept, the 5th is not accepted, level_out=4
  - set ready_in=1 -> outputs 50, 0, 625, 10 in order over 4 cycles
- Level 2, push 100 and pop in the same cycle for 8 cycles:
  - level_out stays 2, output order preserved across pointer wrap
- After 3 pushes with acc_en=1 (last y=625), drive rst_n_in=0 for 1 cycle:
  - valid_out=0, level_out=0, acc_out=0, count_out=0, ready_out=1
  - an asynchronous reset pulse between edges has no effect
- Force count_out to 16'hFFFF via 65535 pushes with ready_in=1, then one push -> count_out=0.
